i_cache_fetch: RTL

I_CACHE_FETCH -- requirements
Module: i_cache_fetch

---
 rtl/i_cache_fetch.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/i_cache_fetch.sv
// Instruction fetch front end: round-robin warp issue into a 2-cycle memory
// read port, tagged S1/S2 pipeline and a 4-entry credit-managed output FIFO.
module i_cache_fetch #(
  parameter int ADDR = 12,
  parameter int DATA = 32,
  parameter int NW   = 8,
  localparam int WID = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_rd,
  output logic [ADDR-1:0] mem_addr,
  input  logic [DATA-1:0] mem_dout,
  input  logic            init_valid,
  input  logic [WID-1:0]  init_warp,
  input  logic [ADDR-1:0] init_pc,
  input  logic            redirect_valid,
  input  logic [WID-1:0]  redirect_warp,
  input  logic [ADDR-1:0] redirect_pc,
  input  logic            halt_valid,
  input  logic [WID-1:0]  halt_warp,
  input  logic [NW-1:0]   warp_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_inst,
  output logic [WID-1:0]  out_warp,
  output logic [ADDR-1:0] out_pc
);

  logic [ADDR-1:0] pc_r [NW];
  logic [NW-1:0]   active_r;
  logic [WID-1:0]  rr_ptr_r;

  logic            s1_v_r, s2_v_r;
  logic [WID-1:0]  s1_w_r, s2_w_r;
  logic [ADDR-1:0] s1_pc_r, s2_pc_r;

  logic [DATA-1:0] fifo_inst_r [4];
  logic [WID-1:0]  fifo_warp_r [4];
  logic [ADDR-1:0] fifo_pc_r   [4];
  logic [3:0]      fifo_kill_r;
  logic [1:0]      head_r, tail_r;
  logic [2:0]      cnt_r;

  logic [NW-1:0]   init_hit_s, redir_hit_s, halt_hit_s, kill_s, eligible_s;
  logic            grant_v_s;
  logic [WID-1:0]  grant_w_s;
  logic [2:0]      credit_s;
  logic            issue_s, push_s, pop_s, head_present_s, head_dead_s;
  logic [WID-1:0]  head_warp_s;

  // Rotated warp index used by the round-robin search.
  function automatic logic [WID-1:0] rr_index(input logic [WID-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    sum = (sum >= NW) ? sum - NW : sum;
    return WID'(sum);
  endfunction

  // Per-warp decode of control ops; any op on a warp flushes its in-flight fetches.
  always_comb begin
    init_hit_s  = {NW{1'b0}};
    redir_hit_s = {NW{1'b0}};
    halt_hit_s  = {NW{1'b0}};
    for (int w = 0; w < NW; w++) begin
      init_hit_s[w]  = init_valid     && (init_warp     == WID'(w));
      redir_hit_s[w] = redirect_valid && (redirect_warp == WID'(w));
      halt_hit_s[w]  = halt_valid     && (halt_warp     == WID'(w));
    end
    kill_s     = init_hit_s | redir_hit_s | halt_hit_s;
    eligible_s = active_r & warp_en & ~kill_s;
  end

  // Round-robin grant starting at rr_ptr_r.
  always_comb begin
    grant_v_s = 1'b0;
    grant_w_s = {WID{1'b0}};
    for (int i = 0; i < NW; i++) begin
      if (!grant_v_s && eligible_s[rr_index(rr_ptr_r, i)]) begin
        grant_v_s = 1'b1;
        grant_w_s = rr_index(rr_ptr_r, i);
      end else begin
        grant_w_s = grant_w_s;
      end
    end
  end

  // Credits cover every slot that may still land in the FIFO, killed entries included.
  assign credit_s = cnt_r + {2'b00, s1_v_r} + {2'b00, s2_v_r};
  assign issue_s  = !rst && grant_v_s && (credit_s < 3'd4);
  assign mem_rd   = issue_s;
  assign mem_addr = pc_r[grant_w_s];

  assign head_present_s = (cnt_r != 3'd0);
  assign head_warp_s    = fifo_warp_r[head_r];
  assign head_dead_s    = fifo_kill_r[head_r] || kill_s[head_warp_s];
  assign out_valid      = !rst && head_present_s && !head_dead_s;
  assign pop_s          = head_present_s && (head_dead_s || out_ready);
  assign push_s         = s2_v_r && !kill_s[s2_w_r];
  assign out_inst       = fifo_inst_r[head_r];
  assign out_warp       = head_warp_s;
  assign out_pc         = fifo_pc_r[head_r];

  // Warp pc/active state; halt beats redirect beats init on the same warp.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r <= {NW{1'b0}};
      for (int w = 0; w < NW; w++) pc_r[w] <= {ADDR{1'b0}};
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (halt_hit_s[w]) begin
          active_r[w] <= 1'b0;
        end else if (redir_hit_s[w]) begin
          pc_r[w] <= redirect_pc;
        end else if (init_hit_s[w]) begin
          pc_r[w]     <= init_pc;
          active_r[w] <= 1'b1;
        end else if (issue_s && (grant_w_s == WID'(w))) begin
          pc_r[w] <= pc_r[w] + {{(ADDR-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Round-robin pointer moves past the last granted warp.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= {WID{1'b0}};
    end else if (issue_s) begin
      rr_ptr_r <= (grant_w_s == WID'(NW - 1)) ? {WID{1'b0}} : grant_w_s + 1'b1;
    end
  end

  // Tag pipeline tracking the two cycles of read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r <= 1'b0;
      s2_v_r <= 1'b0;
    end else begin
      s1_v_r <= issue_s;
      s2_v_r <= s1_v_r && !kill_s[s1_w_r];
    end
    s1_w_r  <= grant_w_s;
    s1_pc_r <= mem_addr;
    s2_w_r  <= s1_w_r;
    s2_pc_r <= s1_pc_r;
  end

  // Output FIFO with per-entry kill marks; a fresh push clears its mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r      <= 2'd0;
      tail_r      <= 2'd0;
      cnt_r       <= 3'd0;
      fifo_kill_r <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        fifo_kill_r[i] <= fifo_kill_r[i] || kill_s[fifo_warp_r[i]];
      end
      if (push_s) begin
        fifo_inst_r[tail_r] <= mem_dout;
        fifo_warp_r[tail_r] <= s2_w_r;
        fifo_pc_r[tail_r]   <= s2_pc_r;
        fifo_kill_r[tail_r] <= 1'b0;
        tail_r              <= tail_r + 2'd1;
      end
      if (pop_s) begin
        head_r <= head_r + 2'd1;
      end
      cnt_r <= cnt_r + {2'b00, push_s} - {2'b00, pop_s};
    end
  end

endmodule
